program_loader: RTL

- Boot-time instruction loader that sits directly upstream of cpu_16bit.
- Consumes a byte stream from a serial receiver: a 16-bit word count, then the instruction words, each sent high byte first.
- Assembles each 16-bit word and writes it into CPU instruction memory through instruction_in, load_address and load_instruction.
- Holds the CPU in pc_reset until the load completes, then releases it.

---
 rtl/program_loader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Boot loader: turns a byte stream (16-bit word count, then words high byte first) into
// CPU instruction-memory writes. Define PROGRAM_LOADER_CHECKSUM_EN for a trailing 16-bit checksum.
module program_loader #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              reload,
    output logic [15:0]       instruction_in,
    output logic [ADDR_W-1:0] load_address,
    output logic              load_instruction,
    output logic              pc_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int unsigned      CNT_W   = 16;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    typedef enum logic [3:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        DONE,
        ERROR
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ,
        CHK_HI,
        CHK_LO
`endif
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] rcvd;
    logic [CNT_W-1:0] rcvd_inc;
    logic [CNT_W-1:0] len_c;
    logic [7:0]       byte_hi;
    logic             xfer;
    logic             ready_d;
    logic             busy_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [15:0]      sum;
`endif

    assign xfer     = rx_valid && rx_ready;
    assign rcvd_inc = rcvd + CNT_W'(1);
    assign len_c    = {count[15:8], rx_data};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Next-state decode plus the state-derived flags, registered below from next_state
    always_comb begin
        next_state = state;
        ready_d    = 1'b0;
        busy_d     = 1'b0;
        case (state)
            IDLE:    next_state = LEN_HI;
            LEN_HI:  if (xfer) next_state = LEN_LO;
            LEN_LO: begin
                if (xfer) begin
                    if (len_c == '0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        next_state = CHK_HI;
`else
                        next_state = DONE;
`endif
                    end else if (len_c > MAX_CNT) begin
                        next_state = ERROR;
                    end else begin
                        next_state = DATA_HI;
                    end
                end
            end
            DATA_HI: if (xfer) next_state = DATA_LO;
            DATA_LO: if (xfer) next_state = WRITE;
            WRITE: begin
                if (rcvd_inc == count) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    next_state = CHK_HI;
`else
                    next_state = DONE;
`endif
                end else begin
                    next_state = DATA_HI;
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CHK_HI:  if (xfer) next_state = CHK_LO;
            CHK_LO: begin
                if (xfer) next_state = ({byte_hi, rx_data} == sum) ? DONE : ERROR;
            end
`endif
            DONE:    if (reload) next_state = IDLE;
            ERROR:   if (reload) next_state = IDLE;
            default: next_state = IDLE;
        endcase

        case (next_state)
            LEN_HI, LEN_LO, DATA_HI, DATA_LO
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            , CHK_HI, CHK_LO
`endif
            :        ready_d = 1'b1;
            default: ready_d = 1'b0;
        endcase
        busy_d = (next_state != IDLE) && (next_state != DONE) && (next_state != ERROR);
    end

    // Registered outputs and datapath; a transition back to IDLE wipes the load context
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_ready         <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
            pc_reset         <= 1'b1;
            load_instruction <= 1'b0;
            instruction_in   <= '0;
            load_address     <= '0;
            count            <= '0;
            rcvd             <= '0;
            byte_hi          <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum              <= '0;
`endif
        end else begin
            rx_ready         <= ready_d;
            busy             <= busy_d;
            done             <= (next_state == DONE);
            error            <= (next_state == ERROR);
            pc_reset         <= (next_state != DONE);
            load_instruction <= (next_state == WRITE);
            if (next_state == IDLE) begin
                load_address <= '0;
                count        <= '0;
                rcvd         <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                sum          <= '0;
`endif
            end else begin
                case (state)
                    LEN_HI:  if (xfer) count[15:8] <= rx_data;
                    LEN_LO:  if (xfer) count[7:0] <= rx_data;
                    DATA_HI: if (xfer) byte_hi <= rx_data;
                    DATA_LO: if (xfer) instruction_in <= {byte_hi, rx_data};
                    WRITE: begin
                        load_address <= load_address + ADDR_W'(1);
                        rcvd         <= rcvd_inc;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        sum          <= sum + instruction_in;
`endif
                    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    CHK_HI:  if (xfer) byte_hi <= rx_data;
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule
